// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D front end: FSM states and the
// IR sensor channel map on the 8-channel ADC.
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TX1  = 3'd1,
        GAP  = 3'd2,
        TX2  = 3'd3,
        DONE = 3'd4
    } a2d_state_t;

    localparam logic [2:0] IR_IN_L  = 3'd0;
    localparam logic [2:0] IR_IN_R  = 3'd1;
    localparam logic [2:0] IR_MID_L = 3'd2;
    localparam logic [2:0] IR_OUT_R = 3'd3;
    localparam logic [2:0] IR_MID_R = 3'd4;
    localparam logic [2:0] IR_OUT_L = 3'd7;

endpackage

// File: rtl/spi_mstr16.sv
// One 16-bit SPI mode-3 transaction: SCLK idles high, MOSI changes on the
// falling edge, MISO is sampled on the rising edge.
module spi_mstr16 #(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int W = SCLK_DIV_W;
    localparam logic [W-1:0] DIV_LOAD = W'(2**W - 10);
    localparam logic [W-1:0] RISE_VAL = W'(2**(W-1) - 1);

    logic         busy;
    logic [W-1:0] div;
    logic [4:0]   bit_cnt;
    logic [15:0]  shift;
    logic         miso_smp;
    logic         fall_evt;
    logic         rise_evt;
    logic         last_evt;

    assign fall_evt = busy && (div == '1);
    assign rise_evt = busy && (div == RISE_VAL);
    assign last_evt = fall_evt && (bit_cnt == 5'd16);

    assign done    = last_evt;
    assign rd_data = shift;
    assign SCLK    = div[W-1];
    assign MOSI    = shift[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            SS_n     <= 1'b1;
            div      <= '1;
            bit_cnt  <= 5'd0;
            shift    <= 16'h0000;
            miso_smp <= 1'b0;
        end else if (wrt && !busy) begin
            busy    <= 1'b1;
            SS_n    <= 1'b0;
            div     <= DIV_LOAD;
            bit_cnt <= 5'd0;
            shift   <= cmd;
        end else if (busy) begin
            if (last_evt) begin
                // div is left at all-ones so SCLK stays high as SS_n rises
                busy  <= 1'b0;
                SS_n  <= 1'b1;
                shift <= {shift[14:0], miso_smp};
            end else begin
                div <= div + W'(1);
                if (rise_evt) begin
                    miso_smp <= MISO;
                    bit_cnt  <= bit_cnt + 5'd1;
                end
                // the fall ending the front porch has no sampled bit yet
                if (fall_evt && (bit_cnt != 5'd0))
                    shift <= {shift[14:0], miso_smp};
            end
        end
    end

endmodule

// File: rtl/a2d_intf.sv
// Conversion sequencer: two SPI frames per request because the ADC returns
// the channel addressed in the previous frame; the second frame holds the result.
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = 5,
    parameter int CS_GAP     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    a2d_state_t       state;
    logic [2:0]       chnnl_lat;
    logic [GAP_W-1:0] gap_cnt;
    logic             spi_wrt;
    logic             spi_done;
    logic [15:0]      spi_cmd;
    logic [15:0]      rd_data;
    logic             rd_unused;

    // in IDLE the request channel goes straight to the SPI so TX1 starts at once
    assign spi_cmd = {2'b00, ((state == IDLE) ? chnnl : chnnl_lat), 11'h000};
    assign spi_wrt = ((state == IDLE) && strt_cnv) ||
                     ((state == GAP) && (gap_cnt == '0));
    assign rd_unused = ^rd_data[15:12];

    spi_mstr16 #(
        .SCLK_DIV_W(SCLK_DIV_W)
    ) u_spi (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrt    (spi_wrt),
        .cmd    (spi_cmd),
        .done   (spi_done),
        .rd_data(rd_data),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            chnnl_lat <= 3'd0;
            gap_cnt   <= '0;
            res       <= 12'h000;
            cnv_cmplt <= 1'b0;
        end else begin
            cnv_cmplt <= 1'b0;
            case (state)
                IDLE: begin
                    if (strt_cnv) begin
                        chnnl_lat <= chnnl;
                        state     <= TX1;
                    end
                end
                TX1: begin
                    if (spi_done) begin
                        gap_cnt <= GAP_W'(CS_GAP - 1);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0)
                        state <= TX2;
                    else
                        gap_cnt <= gap_cnt - GAP_W'(1);
                end
                TX2: begin
                    if (spi_done)
                        state <= DONE;
                end
                DONE: begin
                    res       <= rd_data[11:0];
                    cnv_cmplt <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a behavioural ADC128S-style slave that
// answers each frame with the channel addressed in the previous frame.
module tb_a2d_intf;
    import a2d_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] exp_q[$];
    int          win_q[$];
    int          gap_q[$];
    logic [15:0] mosi_q[$];
    logic [11:0] adc_val[8];

    int pulse_cnt = 0;
    int cyc       = 0;
    int low_len   = 0;
    int high_len  = 0;
    int rise_cyc  = 0;
    int cmplt_cyc = 0;
    logic ss_prev = 1'b1;

    a2d_intf #(
        .SCLK_DIV_W(5),
        .CS_GAP    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .strt_cnv (strt_cnv),
        .chnnl    (chnnl),
        .cnv_cmplt(cnv_cmplt),
        .res      (res),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ADC model
    logic [15:0] rx_sr   = 16'h0000;
    logic [15:0] resp    = 16'h0000;
    logic [2:0]  addr_prev = 3'd0;
    int          rise_n  = 0;
    int          fall_n  = 0;

    always @(negedge SS_n) begin
        rise_n = 0;
        fall_n = 0;
        resp   = {4'h0, adc_val[addr_prev]};
    end

    always @(posedge SCLK) begin
        if (!SS_n) begin
            rx_sr = {rx_sr[14:0], MOSI};
            rise_n++;
        end
    end

    always @(negedge SCLK) begin
        if (!SS_n && fall_n < 16) begin
            MISO = resp[15-fall_n];
            fall_n++;
        end
    end

    always @(posedge SS_n) begin
        if (rise_n == 16) begin
            addr_prev = rx_sr[13:11];
            mosi_q.push_back(rx_sr);
        end
        rise_n = 0;
    end

    // monitor and scoreboard
    always @(negedge clk) begin
        cyc++;
        if (SS_n !== ss_prev) begin
            check("sclk_at_ss_edge", {31'd0, SCLK}, 32'd1);
            if (SS_n) begin
                win_q.push_back(low_len);
                rise_cyc = cyc;
                high_len = 0;
            end else begin
                gap_q.push_back(high_len);
                low_len = 0;
            end
        end
        if (!SS_n) low_len++;
        else       high_len++;
        ss_prev = SS_n;
        if (cnv_cmplt) begin
            pulse_cnt++;
            cmplt_cyc = cyc;
            if (exp_q.size() == 0)
                check("unexpected_pulse", 32'd1, 32'd0);
            else
                check("res", {20'd0, res}, {20'd0, exp_q.pop_front()});
        end
    end

    // driver tasks
    task automatic start_conv(input logic [2:0] ch);
        @(negedge clk);
        strt_cnv = 1'b1;
        chnnl    = ch;
        exp_q.push_back(adc_val[ch]);
        @(negedge clk);
        strt_cnv = 1'b0;
    endtask

    task automatic wait_cmplt(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk);
            if (cnv_cmplt) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int p0;
        logic [2:0] seq[6];
        seq = '{IR_IN_R, IR_IN_L, IR_MID_R, IR_MID_L, IR_OUT_R, IR_OUT_L};
        adc_val = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hA5C, 12'h555, 12'h666, 12'hDEF};
        rst_n    = 1'b0;
        strt_cnv = 1'b0;
        chnnl    = 3'd0;
        MISO     = 1'b0;

        // 1: reset values
        repeat (3) @(negedge clk);
        check("rst_ss_n", {31'd0, SS_n}, 32'd1);
        check("rst_sclk", {31'd0, SCLK}, 32'd1);
        check("rst_mosi", {31'd0, MOSI}, 32'd0);
        check("rst_cmplt", {31'd0, cnv_cmplt}, 32'd0);
        check("rst_res", {20'd0, res}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 2: single conversion on channel 4, frame timing
        win_q.delete();
        gap_q.delete();
        mosi_q.delete();
        p0 = pulse_cnt;
        start_conv(IR_MID_R);
        wait_cmplt("t2_done");
        repeat (4) @(negedge clk);
        check("t2_win_count", win_q.size(), 32'd2);
        if (win_q.size() == 2) begin
            check("t2_win1_len", win_q[0], 32'd522);
            check("t2_win2_len", win_q[1], 32'd522);
        end
        check("t2_gap_count", gap_q.size(), 32'd2);
        if (gap_q.size() == 2) check("t2_gap_len", gap_q[1], 32'd2);
        check("t2_frames", mosi_q.size(), 32'd2);
        if (mosi_q.size() == 2) begin
            check("t2_cmd1", {16'd0, mosi_q[0]}, 32'h2000);
            check("t2_cmd2", {16'd0, mosi_q[1]}, 32'h2000);
        end
        check("t2_latency", cmplt_cyc - rise_cyc, 32'd1);
        check("t2_res", {20'd0, res}, 32'hA5C);
        check("t2_pulses", pulse_cnt - p0, 32'd1);

        // 3: six sequential conversions
        p0 = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            start_conv(seq[i]);
            wait_cmplt("t3_done");
        end
        repeat (4) @(negedge clk);
        check("t3_pulses", pulse_cnt - p0, 32'd6);

        // 4: a second request during TX1 is ignored
        p0 = pulse_cnt;
        mosi_q.delete();
        start_conv(IR_OUT_R);
        repeat (100) @(negedge clk);
        strt_cnv = 1'b1;
        chnnl    = IR_OUT_L;
        @(negedge clk);
        strt_cnv = 1'b0;
        wait_cmplt("t4_done");
        repeat (1200) @(negedge clk);
        check("t4_pulses", pulse_cnt - p0, 32'd1);
        check("t4_res", {20'd0, res}, 32'hABC);
        check("t4_frames", mosi_q.size(), 32'd2);
        if (mosi_q.size() == 2) check("t4_cmd2", {16'd0, mosi_q[1]}, 32'h1800);

        // 5: reset in the middle of TX2
        p0 = pulse_cnt;
        start_conv(IR_MID_L);
        repeat (800) @(negedge clk);
        check("t5_in_tx2", {31'd0, SS_n}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_ss_n", {31'd0, SS_n}, 32'd1);
        check("t5_sclk", {31'd0, SCLK}, 32'd1);
        check("t5_cmplt", {31'd0, cnv_cmplt}, 32'd0);
        check("t5_res", {20'd0, res}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1200) @(negedge clk);
        check("t5_no_pulse", pulse_cnt - p0, 32'd0);
        start_conv(3'd5);
        wait_cmplt("t5_restart_done");
        check("t5_restart_res", {20'd0, res}, 32'h555);

        // 6: full-scale and zero readings
        adc_val[6] = 12'hFFF;
        start_conv(3'd6);
        wait_cmplt("t6_fff_done");
        check("t6_fff", {20'd0, res}, 32'hFFF);
        adc_val[6] = 12'h000;
        start_conv(3'd6);
        wait_cmplt("t6_000_done");
        check("t6_000", {20'd0, res}, 32'h000);
        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
